// File: rtl/cell_score_filter.sv
// Threshold filter for a systolic PE score vector: captures one vector, then
// drains every lane at or above threshold, lowest lane first, into a FWFT hit FIFO.
module cell_score_filter #(
  parameter int NUM_PES    = 64,
  parameter int WIDTH      = 10,
  parameter int FIFO_DEPTH = 16,
  parameter int PE_IDX_W   = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic [NUM_PES*WIDTH-1:0]    V_in,
  input  logic [NUM_PES-1:0]          V_in_valid,
  input  logic                        end_of_query_in,
  input  logic [24:0]                 ref_block_cnt_in,
  input  logic [15:0]                 query_id_in,
  input  logic [31:0]                 cell_score_threshold_in,
  input  logic                        tracking_info_valid_in,
  output logic                        stall_out,
  output logic [15:0]                 hit_query_id,
  output logic [24:0]                 hit_ref_block,
  output logic [PE_IDX_W-1:0]         hit_pe,
  output logic [WIDTH-1:0]            hit_score,
  output logic                        hit_valid,
  input  logic                        hit_rdy,
  output logic                        query_done_out,
  output logic [31:0]                 hit_count_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int REC_W = 16 + 25 + PE_IDX_W + WIDTH;
  localparam logic [PTR_W:0]     DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [NUM_PES-1:0] ONE_C   = NUM_PES'(1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                     state_q, state_d;
  logic [NUM_PES-1:0]         mask_q, mask_d, cap_mask, low_bit;
  logic [NUM_PES*WIDTH-1:0]   vec_q;
  logic [15:0]                qid_q;
  logic [24:0]                ref_q;
  logic                       eoq_q;
  logic                       done_q, done_d;
  logic [31:0]                hit_count_q;

  logic [REC_W-1:0]           mem [FIFO_DEPTH];
  logic [PTR_W-1:0]           wptr_q, rptr_q;
  logic [PTR_W:0]             count_q;

  logic                       full, push, pop, single, capture, last_push, found;
  logic [PE_IDX_W-1:0]        sel_lane;
  logic [WIDTH-1:0]           sel_score;
  logic [REC_W-1:0]           head;

  always_comb begin
    cap_mask = '0;
    for (int unsigned i = 0; i < NUM_PES; i++) begin
      cap_mask[i] = V_in_valid[i] &&
                    (32'(V_in[i*WIDTH +: WIDTH]) >= cell_score_threshold_in);
    end
  end

  always_comb begin
    sel_lane  = '0;
    sel_score = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < NUM_PES; i++) begin
      if (mask_q[i] && !found) begin
        found     = 1'b1;
        sel_lane  = PE_IDX_W'(i);
        sel_score = vec_q[i*WIDTH +: WIDTH];
      end
    end
  end

  // Two's-complement trick isolates the lowest set lane; the mask holds a
  // single bit exactly when it equals that isolated bit.
  assign low_bit   = mask_q & (~mask_q + ONE_C);
  assign single    = (mask_q != '0) && (mask_q == low_bit);

  assign full      = (count_q == DEPTH_C);
  assign hit_valid = (count_q != '0);
  assign pop       = hit_valid && hit_rdy;
  assign push      = (state_q == DRAIN) && !full;
  assign last_push = push && single;
  assign stall_out = (state_q == DRAIN) && !(single && !full);
  assign capture   = !stall && !stall_out && tracking_info_valid_in && (V_in_valid != '0);

  always_comb begin
    mask_d = push ? (mask_q & ~low_bit) : mask_q;
    if (capture) mask_d = cap_mask;
    state_d = (mask_d != '0) ? DRAIN : IDLE;
    done_d  = (last_push && eoq_q) ||
              (capture && (cap_mask == '0) && end_of_query_in);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      vec_q       <= '0;
      qid_q       <= '0;
      ref_q       <= '0;
      eoq_q       <= 1'b0;
      done_q      <= 1'b0;
      hit_count_q <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
      if (capture) begin
        vec_q <= V_in;
        qid_q <= query_id_in;
        ref_q <= ref_block_cnt_in;
        eoq_q <= end_of_query_in;
      end
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push && (hit_count_q != '1)) hit_count_q <= hit_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= {qid_q, ref_q, sel_lane, sel_score};
  end

  // Gating with hit_valid keeps the data outputs at zero while empty and in reset.
  assign head = hit_valid ? mem[rptr_q] : '0;
  assign {hit_query_id, hit_ref_block, hit_pe, hit_score} = head;

  assign query_done_out = done_q;
  assign hit_count_out  = hit_count_q;

endmodule

// File: doc/cell_score_filter.md
CELL_SCORE_FILTER -- requirements
Module: cell_score_filter

Interface
REQ-001 Parameter NUM_PES, default 64: number of PE score lanes.
REQ-002 Parameter WIDTH, default 10: bits per cell score.
REQ-003 Parameter FIFO_DEPTH, default 16: hit FIFO entries, power of two, at least 2.
REQ-004 Parameter PE_IDX_W, default 6: lane index width, equal to ceil(log2(NUM_PES)).
REQ-005 clk  in  1  system clock; all flops rise on clk.
REQ-006 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-007 stall  in  1  global pipeline stall; when 1, V_in and tag inputs are not new.
REQ-008 V_in  in  NUM_PES*WIDTH  cell scores; lane i occupies bits [i*WIDTH +: WIDTH]; unsigned.
REQ-009 V_in_valid  in  NUM_PES  per-lane score valid.
REQ-010 end_of_query_in  in  1  this score vector contains the query's final column.
REQ-011 ref_block_cnt_in  in  25  reference block tag for V_in.
REQ-012 query_id_in  in  16  query tag for V_in.
REQ-013 cell_score_threshold_in  in  32  report threshold.
REQ-014 tracking_info_valid_in  in  1  tags and threshold are valid.
REQ-015 stall_out  out  1  filter busy; upstream SHALL hold V_in and tags while 1.
REQ-016 hit_query_id  out  16, hit_ref_block  out  25, hit_pe  out  PE_IDX_W, hit_score  out  WIDTH: head FIFO record.
REQ-017 hit_valid  out  1  head record valid; hit_rdy  in  1  consumer accepts head.
REQ-018 query_done_out  out  1  one-cycle pulse after the end-of-query vector has fully drained.
REQ-019 hit_count_out  out  32  total records pushed since reset, saturating at 0xFFFFFFFF.

Function
REQ-020 Capture SHALL occur in cycles where stall=0, stall_out=0, tracking_info_valid_in=1, and V_in_valid is non-zero. Any other input cycle is ignored.
REQ-021 Capture SHALL register the tags, end_of_query_in, V_in, and pending_mask. Lane i of pending_mask is set iff V_in_valid[i]=1 and zero-extended score >= cell_score_threshold_in (unsigned 32-bit compare).
REQ-022 If a capture yields pending_mask=0, it SHALL produce no records. If end_of_query_in=1 in that capture, query_done_out SHALL pulse in the next cycle.
REQ-023 FSM states: IDLE (pending_mask=0) and DRAIN (pending_mask!=0).
- IDLE->DRAIN on a capture with a non-zero mask.
- DRAIN->IDLE when the last set bit is pushed.
REQ-024 In DRAIN, each cycle the FIFO is not full, the lowest-indexed set lane SHALL be pushed as {query_id, ref_block, lane, score}, and its mask bit SHALL be cleared.
REQ-025 A push SHALL be blocked when the FIFO is full at the cycle start, even if a pop occurs in the same cycle.
REQ-026 stall_out (combinational) SHALL be 1 when in DRAIN, unless exactly one bit is pending and the FIFO is not full. In that case stall_out=0 and a new capture may occur in the same cycle the final push happens.
REQ-027 query_done_out SHALL pulse in the cycle after the final push of a capture tagged end_of_query.
REQ-028 Capture-to-first-push latency SHALL be 1 cycle when the FIFO is not full.
REQ-029 The FIFO SHALL be first-word-fall-through, with hit_valid = not empty. A pop occurs when hit_valid=1 and hit_rdy=1.
REQ-030 Simultaneous push and pop SHALL keep occupancy unchanged. Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-031 The stall input SHALL NOT freeze draining or the FIFO; it only blocks capture.
REQ-032 hit_count_out SHALL increment by 1 per push and SHALL hold at 0xFFFFFFFF.

Reset
REQ-033 rst=0 SHALL immediately force the following, including mid-DRAIN, discarding all pending and FIFO records:
- state IDLE, pending_mask=0;
- FIFO empty, hit_valid=0;
- stall_out=0, query_done_out=0, hit_count_out=0;
- hit_* data outputs = 0.
REQ-034 The first capture SHALL be possible in the first clk edge after rst returns to 1.

Verification
REQ-035 Single hit: threshold=20, lane 5 score 25 valid, other lanes 10, query_id=0x0007, ref_block=3, hit_rdy=1 -> one record {7,3,5,25} one cycle after capture; stall_out stays 0; hit_count_out=1.
REQ-036 Multi-hit: lanes 2, 9, 40 >= threshold -> records pushed in lane order 2, 9, 40 on consecutive cycles. stall_out=1 for 2 cycles, and the next capture occurs on the third push cycle.
REQ-037 Backpressure: hit_rdy=0 with FIFO_DEPTH+3 hits pending -> FIFO fills to 16 and stall_out holds 1. After hit_rdy=1, all 19 records emerge in order with none lost or duplicated.
REQ-038 Boundaries:
- score equal to threshold is reported; score below is not;
- threshold 0x00000400 with WIDTH=10 yields no hits;
- tracking_info_valid_in=0 capture is ignored.
REQ-039 End of query: end_of_query_in=1 with 2 hits -> query_done_out pulses the cycle after the second push. With 0 hits, query_done_out pulses the cycle after capture.
REQ-040 Reset mid-drain: assert rst=0 while 3 hits are pending and the FIFO holds 4 -> outputs take their reset values immediately. After release, a new single hit emerges alone.
